// File: rtl/iter_div.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle: IDLE -> RUN x WIDTH -> FIX -> DONE.
// Define DIV_ZERO_FAST_EN to add the div_zero output and a short path for a zero divisor.
module iter_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FAST_EN
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dd_q, dd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] dd_abs, ds_abs;
  logic             dd_neg, ds_neg;

  assign dd_neg  = is_signed & dividend[WIDTH-1];
  assign ds_neg  = is_signed & divisor[WIDTH-1];
  assign dd_abs  = dd_neg ? -dividend : dividend;
  assign ds_abs  = ds_neg ? -divisor : divisor;
  // Partial remainder gains the next dividend bit; a non-negative trial keeps the subtraction.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

`ifdef DIV_ZERO_FAST_EN
  logic div_zero_q, div_zero_d;
  assign div_zero = div_zero_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dd_d        = dd_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_FAST_EN
    div_zero_d  = div_zero_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          dd_d    = dividend;
          qneg_d  = dd_neg ^ ds_neg;
          rneg_d  = dd_neg;
          quo_d   = dd_abs;
          rem_d   = '0;
          dvs_d   = ds_abs;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          state_d = StRun;
`ifdef DIV_ZERO_FAST_EN
          div_zero_d = (divisor == '0);
          if (divisor == '0) state_d = StFix;
`endif
        end
      end
      StRun: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) state_d = StFix;
      end
      StFix: begin
        // A zero divisor would give a sign-flipped all-ones quotient; force the defined result.
        quotient_d  = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
        remainder_d = dz_q ? dd_q : (rneg_q ? -rem_q : rem_q);
        state_d     = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dd_q        <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dd_q        <= dd_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_zero_q <= 1'b0;
    else        div_zero_q <= div_zero_d;
  end
`endif

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div (WIDTH=32): edge-count reference model checked every cycle,
// plus literal expectations per scenario.
module tb_iter_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef DIV_ZERO_FAST_EN
  logic        div_zero;
  localparam int DzLat = 1;
`else
  localparam int DzLat = 33;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int edge_no  = 0;
  int base     = 0;

  iter_div #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIV_ZERO_FAST_EN
    .remainder (remainder),
    .div_zero  (div_zero)
`else
    .remainder (remainder)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  // Reference result from plain arithmetic: {quotient, remainder}.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  // Cycle model: latency counted in edges after the accepting edge.
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_q, m_r, p_q, p_r;
  int          m_cnt, m_lat;
  logic [63:0] tmp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          tmp    = ref_div(is_signed, dividend, divisor);
          p_q    <= tmp[63:32];
          p_r    <= tmp[31:0];
          m_lat  <= (divisor == 32'd0) ? DzLat : 33;
          m_cnt  <= 0;
          m_busy <= 1'b1;
          m_dz   <= (divisor == 32'd0);
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_lat) begin
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
        end
        if (m_cnt + 1 == m_lat + 1) m_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("model_done", {31'd0, done}, {31'd0, m_done});
    chk("model_quotient", quotient, m_q);
    chk("model_remainder", remainder, m_r);
`ifdef DIV_ZERO_FAST_EN
    chk("model_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
`endif
  end

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    base  = edge_no;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [31:0] q,
                           input logic [31:0] r);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (done) found = 1;
    end
    chk({nm, "_done_seen"}, {31'd0, found}, 32'd1);
    chk({nm, "_latency"}, edge_no - base, lat);
    chk({nm, "_q"}, quotient, q);
    chk({nm, "_r"}, remainder, r);
    @(posedge clk);
    #1;
    chk({nm, "_busy_clear"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] q,
                        input logic [31:0] r);
    start_op(s, a, b);
    wait_done(nm, lat, q, r);
  endtask

  initial begin
    int ndone;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("u_dz", 1'b0, 32'h1234_5678, 32'd0, DzLat, 32'hFFFF_FFFF, 32'h1234_5678);
`ifdef DIV_ZERO_FAST_EN
    chk("u_dz_flag", {31'd0, div_zero}, 32'd1);
`endif
    run_op("s_dz", 1'b1, 32'hF000_0000, 32'd0, DzLat, 32'hFFFF_FFFF, 32'hF000_0000);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);

    // Start re-asserted with other operands at edges 5, 33 and in the DONE cycle.
    start_op(1'b0, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd55; divisor = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign5_busy", {31'd0, busy}, 32'd1);
    repeat (27) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("ign33_done", {31'd0, done}, 32'd1);
    chk("ign33_q", quotient, 32'd100);
    chk("ign33_r", remainder, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign34_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("ign_no_second_done", ndone, 0);
    chk("ign_q_held", quotient, 32'd100);

    // Asynchronous reset in the middle of RUN.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op("post_rst_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
